// File: rtl/sort_host_ctrl.sv
// Host-side controller for the sorter core: loads DEPTH words, pulses start, waits for done, streams the sorted RAM out.
// Build option: define SORT_HOST_DESC_EN to read the RAM from DEPTH-1 down to 0 (descending output).
module sort_host_ctrl #(
  parameter int N     = 8,
  parameter int L     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         sort_wrinit,
  output logic         sort_rd,
  output logic [L-1:0] sort_raddr,
  output logic [N-1:0] sort_datain,
  output logic         sort_start,
  input  logic [N-1:0] sort_dataout,
  input  logic         sort_done
);

  localparam int IW = L + 1;
  localparam logic [IW-1:0] ONE      = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

`ifdef SORT_HOST_DESC_EN
  localparam logic [IW-1:0] RD_FIRST = LAST_IDX;
  localparam logic [IW-1:0] RD_END   = '0;
`else
  localparam logic [IW-1:0] RD_FIRST = '0;
  localparam logic [IW-1:0] RD_END   = LAST_IDX;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx_next;
  logic            done_prev_q, done_prev_d;
  logic            busy_q, busy_d;
  logic            wrinit_q, wrinit_d;
  logic            rd_q, rd_d;
  logic            start_q, start_d;
  logic [L-1:0]    raddr_q, raddr_d;
  logic [N-1:0]    datain_q, datain_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            in_hs;

  assign in_ready = !rst && (state_q == S_IDLE || state_q == S_LOAD);
  assign in_hs    = in_valid && in_ready;

`ifdef SORT_HOST_DESC_EN
  assign idx_next = idx_q - ONE;
`else
  assign idx_next = idx_q + ONE;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_prev_d = done_prev_q;
    busy_d      = busy_q;
    wrinit_d    = 1'b0;
    rd_d        = 1'b0;
    start_d     = 1'b0;
    raddr_d     = raddr_q;
    datain_d    = datain_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (in_hs) begin
          wrinit_d = 1'b1;
          raddr_d  = '0;
          datain_d = in_data;
          idx_d    = ONE;
          busy_d   = 1'b1;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_hs) begin
          wrinit_d = 1'b1;
          raddr_d  = idx_q[L-1:0];
          datain_d = in_data;
          idx_d    = idx_q + ONE;
          if (idx_q == LAST_IDX) state_d = S_START;
        end
      end

      S_START: begin
        start_d     = 1'b1;
        // Seed with the current level: a done still held high from the previous
        // job must fall and rise again before it counts as completion.
        done_prev_d = sort_done;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        done_prev_d = sort_done;
        if (sort_done && !done_prev_q) begin
          idx_d   = RD_FIRST;
          rd_d    = 1'b1;
          raddr_d = RD_FIRST[L-1:0];
          state_d = S_RD_REQ;
        end
      end

      // sort_rd is visible during this state; data returns one cycle later.
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        out_data_d  = sort_dataout;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == RD_END);
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_next;
            rd_d    = 1'b1;
            raddr_d = idx_next[L-1:0];
            state_d = S_RD_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      done_prev_q <= 1'b0;
      busy_q      <= 1'b0;
      wrinit_q    <= 1'b0;
      rd_q        <= 1'b0;
      start_q     <= 1'b0;
      raddr_q     <= '0;
      datain_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_prev_q <= done_prev_d;
      busy_q      <= busy_d;
      wrinit_q    <= wrinit_d;
      rd_q        <= rd_d;
      start_q     <= start_d;
      raddr_q     <= raddr_d;
      datain_q    <= datain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy        = busy_q;
  assign sort_wrinit = wrinit_q;
  assign sort_rd     = rd_q;
  assign sort_start  = start_q;
  assign sort_raddr  = raddr_q;
  assign sort_datain = datain_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;

endmodule
